bram_sdp: RTL
=============

Name: bram_sdp

Overview:
Parametrised simple-dual-port block RAM: one write port with byte enables, one read port. Configurable read latency, read-during-write collision mode, and a built-in clear sequencer that zeroes the array after reset or on request. Drop-in storage for line buffers, sample buffers and lookup tables across the project. It replaces ad-hoc fixed 8-bit/16-entry memories.

Parameters:
DATA_W, 8, word width in bits; must be a multiple of 8.
DEPTH, 32, number of words; need not be a power of two.
RD_LATENCY, 1, read latency in cycles; legal values are 1 or 2 only.
RDW_MODE, 0, same-address read/write collision behaviour: 0 = read-first (old data), 1 = write-first (new data).
ADDR_W, $clog2(DEPTH), address width; derived localparam, not overridable.

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
clear_req  in  1  one-cycle pulse requesting a full-array clear
busy  out  1  high while the clear sequencer owns the array
wr_en  in  1  write request
wr_addr  in  ADDR_W  write address
wr_be  in  DATA_W/8  byte enables; bit i covers data[8i+7:8i]
wr_data  in  DATA_W  write data
rd_en  in  1  read request
rd_addr  in  ADDR_W  read address
rd_data  out  DATA_W  read data
rd_valid  out  1  rd_data is valid this cycle

Behaviour:
- Reset (rst_n low, asynchronous): rd_data=0, rd_valid=0, read pipeline cleared, busy=1, FSM=CLEAR, clr_addr=0. Array contents are not reset directly.
- FSM states: IDLE and CLEAR.
  - CLEAR: each cycle writes all-zero to clr_addr, then clr_addr++.
  - After writing DEPTH-1, FSM goes to IDLE; busy is 0 from the next cycle.
  - Result: busy is high for exactly DEPTH cycles after rst_n deasserts.
  - IDLE to CLEAR on clear_req=1 with clr_addr=0; busy rises the following cycle.
  - clear_req while in CLEAR is ignored (no restart).
  - rst_n asserted mid-clear restarts the sweep at 0.
- While busy=1, wr_en and rd_en are ignored: no write, no rd_valid.
- Reads already in the pipeline when a clear starts still complete. They return data as of their issue cycle, subject to the collision rules below.
- Write (IDLE, wr_en=1, wr_addr<DEPTH): bytes with wr_be[i]=1 are updated at the clock edge; other bytes are unchanged. wr_be=0 is a no-op.
- Read (IDLE, rd_en=1):
  - rd_valid=1 exactly RD_LATENCY cycles after the issue edge.
  - RD_LATENCY=2 adds one output register stage.
  - Back-to-back reads are fully pipelined, one per cycle.
  - When rd_valid=0, rd_data holds its last value.
- Out of range (addr>=DEPTH): write is dropped; read still produces rd_valid with rd_data=0.
- Same-cycle rd_en and wr_en to the same address:
  - RDW_MODE=0: returns the pre-write word.
  - RDW_MODE=1: returns the merged word (new bytes where wr_be=1, old bytes elsewhere).
  - Different addresses never interact.
- A read issued the cycle after a write to the same address returns the new data in both modes. In the RD_LATENCY=2 pipeline this needs no forwarding beyond the RAM itself.

Decomposition:
- Package bram_pkg holds:
  - rdw_mode_e (RDW_READ_FIRST=0, RDW_WRITE_FIRST=1).
  - clr_state_e (CLR_IDLE, CLR_CLEAR).
  - A function be_merge(old, new, be) shared with future RAM variants.
- The clear FSM and address counter form a natural sub-module, bram_clear_seq. It outputs busy, clr_we and clr_addr, and the parent muxes it onto the write port.
- Array plus read pipeline stay in bram_sdp.

Test Plan:
- Reset then idle, DEPTH=32: busy=1 for 32 cycles after rst_n rises, then 0. Read every address -> all return 0 with rd_valid at +RD_LATENCY.
- DATA_W=32, write 0xAABBCCDD to addr 5 (be=4'hF), then addr 5 with be=4'b0101 and data 0x11223344 -> read returns 0xAA22CC44. RD_LATENCY=2: rd_valid exactly 2 cycles after rd_en.
- Collision: addr 7 holds 0x10. Same cycle: write 0x20 and read addr 7 -> RDW_MODE=0 returns 0x10, RDW_MODE=1 returns 0x20. The next-cycle read returns 0x20 in both modes.
- DEPTH=20: write addr 25 is dropped; read addr 25 gives rd_valid=1, rd_data=0; addr 19 read/write works normally.
- Fill array with 0xFF, pulse clear_req (a second pulse mid-sweep is ignored) -> busy for DEPTH cycles, rd_en ignored during busy, all words read 0 afterward.
- Assert rst_n low at clr_addr=10 mid-clear -> rd_valid=0 immediately; after release busy lasts a full DEPTH cycles again.

Source files
------------

// File: rtl/bram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bram_pkg
//  Description : Shared types and helpers for the block-RAM family.
//                rdw_mode_e  - same-address read/write collision behaviour
//                clr_state_e - state encoding of the clear sequencer
//                be_merge    - byte-lane merge under a byte enable
//  Revision    : 1.0 - initial release
// ============================================================================
package bram_pkg;

    typedef enum logic {
        RDW_READ_FIRST  = 1'b0,
        RDW_WRITE_FIRST = 1'b1
    } rdw_mode_e;

    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_CLEAR = 1'b1
    } clr_state_e;

    // Merge one byte lane: the new byte wins where its enable is set.
    // Wider words are built by applying this lane by lane.
    function automatic logic [7:0] be_merge(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       be
    );
        return be ? new_byte : old_byte;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bram_sdp_if.sv
`default_nettype none
// ============================================================================
//  Module      : bram_sdp_if
//  Description : Bus bundle for the simple-dual-port RAM.
//                master: clear_req, wr_en/wr_addr/wr_be/wr_data, rd_en/rd_addr
//                        driven; busy, rd_data, rd_valid observed
//                slave : the RAM side of the same signals
//  Revision    : 1.0 - initial release
// ============================================================================
interface bram_sdp_if
    import bram_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic                  clear_req;
    logic                  busy;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W/8-1:0]   wr_be;
    logic [DATA_W-1:0]     wr_data;
    logic                  rd_en;
    logic [ADDR_W-1:0]     rd_addr;
    logic [DATA_W-1:0]     rd_data;
    logic                  rd_valid;

    modport master (
        output clear_req, wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
        input  busy, rd_data, rd_valid
    );

    modport slave (
        input  clear_req, wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
        output busy, rd_data, rd_valid
    );

endinterface
`default_nettype wire

// File: rtl/bram_clear_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bram_clear_seq
//  Description : Clear sequencer. Sweeps every address once writing zero,
//                starting out of reset or on a clear_req pulse.
//                clk, rst_n  - clock / async active-low reset
//                clear_req   - one-cycle request for a full sweep
//                busy        - sequencer owns the write port
//                clr_we      - zero-write strobe for clr_addr
//                clr_addr    - address being cleared this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_clear_seq
    import bram_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
)(
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              clear_req,
    output logic                   busy,
    output logic                   clr_we,
    output logic [ADDR_W-1:0]      clr_addr
);

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

    clr_state_e          r_state;
    clr_state_e          w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_addr_nxt;

    // Reset lands in CLEAR so the array is swept after every reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CLR_CLEAR;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        clr_we      = 1'b0;
        case (r_state)
            CLR_IDLE: begin
                if (clear_req) begin
                    w_state_nxt = CLR_CLEAR;
                    w_addr_nxt  = '0;
                end
            end
            CLR_CLEAR: begin
                // clear_req is deliberately not looked at here: no restart.
                clr_we = 1'b1;
                if (r_addr == c_last_addr) begin
                    w_state_nxt = CLR_IDLE;
                    w_addr_nxt  = '0;
                end else begin
                    w_addr_nxt  = r_addr + ADDR_W'(1);
                end
            end
            default: begin
                w_state_nxt = CLR_IDLE;
                w_addr_nxt  = '0;
            end
        endcase
    end

    assign busy     = (r_state == CLR_CLEAR);
    assign clr_addr = r_addr;

endmodule
`default_nettype wire

// File: rtl/bram_sdp.sv
`default_nettype none
// ============================================================================
//  Module      : bram_sdp
//  Description : Simple-dual-port block RAM with byte-enable writes,
//                1- or 2-cycle read latency, selectable read-during-write
//                behaviour and a built-in clear sweep.
//                clk, rst_n - clock / async active-low reset
//                bus        - bram_sdp_if.slave (clear, write, read ports)
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_sdp
    import bram_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 32,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 0
)(
    input  wire logic     clk,
    input  wire logic     rst_n,
    bram_sdp_if.slave     bus
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int c_nbytes = DATA_W / 8;
    localparam logic [ADDR_W:0] c_depth = (ADDR_W + 1)'(DEPTH);
    localparam bit c_write_first = (RDW_MODE == int'(RDW_WRITE_FIRST));

    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_busy;
    logic                w_clr_we;
    logic [ADDR_W-1:0]   w_clr_addr;

    logic                w_wr_fire;
    logic                w_rd_fire;
    logic                w_rd_in_range;
    logic                w_collide;
    logic [ADDR_W-1:0]   w_port_addr;
    logic [c_nbytes-1:0] w_port_be;
    logic [DATA_W-1:0]   w_port_data;
    logic [DATA_W-1:0]   w_rd_old;
    logic [DATA_W-1:0]   w_rd_merged;
    logic [DATA_W-1:0]   w_rd_word;

    logic                r_rd_valid;
    logic [DATA_W-1:0]   r_rd_data;

    bram_clear_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_req (bus.clear_req),
        .busy      (w_busy),
        .clr_we    (w_clr_we),
        .clr_addr  (w_clr_addr)
    );

    // User traffic is only accepted while the sequencer is idle.
    assign w_wr_fire     = bus.wr_en & ~w_busy & ({1'b0, bus.wr_addr} < c_depth);
    assign w_rd_fire     = bus.rd_en & ~w_busy;
    assign w_rd_in_range = ({1'b0, bus.rd_addr} < c_depth);
    assign w_collide     = w_wr_fire & (bus.wr_addr == bus.rd_addr);

    // Single write port shared by the sweep and the user.
    assign w_port_addr = w_busy ? w_clr_addr : bus.wr_addr;
    assign w_port_be   = w_busy ? {c_nbytes{w_clr_we}}
                                : (w_wr_fire ? bus.wr_be : '0);
    assign w_port_data = w_busy ? '0 : bus.wr_data;

    always_ff @(posedge clk) begin
        for (int i = 0; i < c_nbytes; i++) begin
            if (w_port_be[i]) begin
                r_mem[w_port_addr][8*i +: 8] <= w_port_data[8*i +: 8];
            end
        end
    end

    // Array read happens before the edge's write lands, which gives the
    // read-first result for free; write-first substitutes the merged word.
    assign w_rd_old = r_mem[bus.rd_addr];

    always_comb begin
        w_rd_merged = w_rd_old;
        for (int i = 0; i < c_nbytes; i++) begin
            w_rd_merged[8*i +: 8] = be_merge(w_rd_old[8*i +: 8],
                                             bus.wr_data[8*i +: 8],
                                             bus.wr_be[i]);
        end
    end

    always_comb begin
        w_rd_word = w_rd_old;
        if (!w_rd_in_range) begin
            w_rd_word = '0;
        end else if (c_write_first && w_collide) begin
            w_rd_word = w_rd_merged;
        end
    end

    // Read data is captured at the issue edge, so reads in flight when a
    // sweep starts still return the word as it was when they were issued.
    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic              r_s1_valid;
            logic [DATA_W-1:0] r_s1_data;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s1_valid <= 1'b0;
                    r_s1_data  <= '0;
                    r_rd_valid <= 1'b0;
                    r_rd_data  <= '0;
                end else begin
                    r_s1_valid <= w_rd_fire;
                    if (w_rd_fire) begin
                        r_s1_data <= w_rd_word;
                    end
                    r_rd_valid <= r_s1_valid;
                    if (r_s1_valid) begin
                        r_rd_data <= r_s1_data;
                    end
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rd_valid <= 1'b0;
                    r_rd_data  <= '0;
                end else begin
                    r_rd_valid <= w_rd_fire;
                    if (w_rd_fire) begin
                        r_rd_data <= w_rd_word;
                    end
                end
            end
        end
    endgenerate

    assign bus.busy     = w_busy;
    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_data  = r_rd_data;

endmodule
`default_nettype wire
